pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 14 +
 rtl/load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hazard_state_e : controller state encoding (RUN=0, LOAD_STALL=1, HALTED=2)
//   StallCountW    : width of the saturating stall-cycle counter
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StHalted    = 2'd2
    } hazard_state_e;

    localparam int unsigned StallCountW = 16;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   rs1, rs2           : source registers of the instruction in ID
//   uses_rs1, uses_rs2 : ID instruction actually reads that source
//   rd                 : destination register of the instruction in EX
//   is_load, wr_en     : EX instruction is a load / writes the register file
//   hazard             : ID needs a value the EX load has not produced yet
// Register 0 is deliberately not exempt.
module load_use_detect #(
    parameter int unsigned REG_AW = 3
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              is_load,
    input  logic              wr_en,
    output logic              hazard
);

    always_comb begin
        hazard = is_load && wr_en &&
                 ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and halt.
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   id_*               : source operands of the instruction in ID
//   ex_*               : destination / kind of the instruction in EX
//   branch_taken       : redirect resolved in EX (highest priority)
//   halt_req           : halt instruction in EX
//   pc_stall, ifid_stall, ifid_flush, idex_flush : pipeline controls (same cycle)
//   halted             : processor halted until reset
//   stall_count        : saturating count of non-halted stall cycles
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW       = 3,
    parameter int unsigned LOAD_BUBBLES = 1  // legal range 1..3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   ex_is_load,
    input  logic                   ex_writeOrder,
    input  logic                   branch_taken,
    input  logic                   halt_req,
    output logic                   pc_stall,
    output logic                   ifid_stall,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   halted,
    output logic [StallCountW-1:0] stall_count
);

    hazard_state_e          state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [StallCountW-1:0] stall_count_q, stall_count_d;
    logic                   hazard;
    logic                   stall_c, flush_if_c, flush_ex_c;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2),
        .rd       (ex_rd),
        .is_load  (ex_is_load),
        .wr_en    (ex_writeOrder),
        .hazard   (hazard)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_c    = 1'b0;
        flush_if_c = 1'b0;
        flush_ex_c = 1'b0;
        case (state_q)
            StRun, StLoadStall: begin
                if (branch_taken) begin
                    // The redirect squashes whatever was stalled behind the load.
                    flush_if_c = 1'b1;
                    flush_ex_c = 1'b1;
                    state_d    = StRun;
                    cnt_d      = 2'd0;
                end else if (halt_req) begin
                    stall_c    = 1'b1;
                    flush_ex_c = 1'b1;
                    state_d    = StHalted;
                    cnt_d      = 2'd0;
                end else if (state_q == StLoadStall) begin
                    // EX now holds a bubble, so ex_* are not looked at here.
                    stall_c    = 1'b1;
                    flush_ex_c = 1'b1;
                    if (cnt_q == 2'd1) begin
                        state_d = StRun;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end else if (hazard) begin
                    stall_c    = 1'b1;
                    flush_ex_c = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = StLoadStall;
                        cnt_d   = 2'(LOAD_BUBBLES - 1);
                    end
                end
            end
            StHalted: begin
                stall_c    = 1'b1;
                flush_ex_c = 1'b1;
            end
            default: begin
                state_d = StRun;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_c && (state_q != StHalted) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + StallCountW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            cnt_q         <= 2'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Controls are combinational from inputs, so they are masked explicitly during reset.
    assign pc_stall    = reset & stall_c;
    assign ifid_stall  = reset & stall_c;
    assign ifid_flush  = reset & flush_if_c;
    assign idex_flush  = reset & flush_ex_c;
    assign halted      = reset & (state_q == StHalted);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_BUBBLES 1 and 3) share stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_is_load = 0, ex_writeOrder = 0;
    logic       branch_taken = 0, halt_req = 0;

    // ctl = {pc_stall, ifid_stall, ifid_flush, idex_flush}
    logic [3:0]  ctl_a, ctl_b;
    logic        hlt_a, hlt_b;
    logic [15:0] cnt_a, cnt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.REG_AW(3), .LOAD_BUBBLES(1)) u_dut_a (
        .clock (clock), .reset (reset),
        .id_rs1 (id_rs1), .id_rs2 (id_rs2),
        .id_uses_rs1 (id_uses_rs1), .id_uses_rs2 (id_uses_rs2),
        .ex_rd (ex_rd), .ex_is_load (ex_is_load), .ex_writeOrder (ex_writeOrder),
        .branch_taken (branch_taken), .halt_req (halt_req),
        .pc_stall (ctl_a[3]), .ifid_stall (ctl_a[2]),
        .ifid_flush (ctl_a[1]), .idex_flush (ctl_a[0]),
        .halted (hlt_a), .stall_count (cnt_a)
    );

    pipeline_hazard_ctrl #(.REG_AW(3), .LOAD_BUBBLES(3)) u_dut_b (
        .clock (clock), .reset (reset),
        .id_rs1 (id_rs1), .id_rs2 (id_rs2),
        .id_uses_rs1 (id_uses_rs1), .id_uses_rs2 (id_uses_rs2),
        .ex_rd (ex_rd), .ex_is_load (ex_is_load), .ex_writeOrder (ex_writeOrder),
        .branch_taken (branch_taken), .halt_req (halt_req),
        .pc_stall (ctl_b[3]), .ifid_stall (ctl_b[2]),
        .ifid_flush (ctl_b[1]), .idex_flush (ctl_b[0]),
        .halted (hlt_b), .stall_count (cnt_b)
    );

    typedef struct {
        logic [2:0] rs1, rs2, rd;
        logic       u1, u2, ld, wr, br, hlt;
    } in_t;

    typedef struct {
        in_t         i;
        logic [3:0]  ctl;
        logic        hlt_o;
        logic [15:0] cnt;
    } vec_t;

    // Reference model: remaining bubbles owed, halted flag, stall total.
    int lb [2] = '{1, 3};
    int rem [2];
    bit mh [2];
    int mcnt [2];

    function automatic in_t mk(int rs1, int rs2, int rd, bit u1, bit u2, bit ld, bit wr,
                               bit br, bit hlt);
        in_t r;
        r.rs1 = 3'(rs1); r.rs2 = 3'(rs2); r.rd = 3'(rd);
        r.u1 = u1; r.u2 = u2; r.ld = ld; r.wr = wr; r.br = br; r.hlt = hlt;
        return r;
    endfunction

    function automatic vec_t vec(in_t i, logic [3:0] ctl, logic h, int cnt);
        vec_t v;
        v.i = i; v.ctl = ctl; v.hlt_o = h; v.cnt = 16'(cnt);
        return v;
    endfunction

    function automatic bit ref_hazard();
        return ex_is_load && ex_writeOrder &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [3:0] model_ctl(int k);
        if (!reset) return 4'b0000;
        if (mh[k]) return 4'b1101;
        if (branch_taken) return 4'b0011;
        if (halt_req || rem[k] > 0 || ref_hazard()) return 4'b1101;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; mh[k] = 0; mcnt[k] = 0;
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] c;
            c = model_ctl(k);
            if (c[3] && !mh[k] && mcnt[k] < 65535) mcnt[k]++;
            if (mh[k]) begin
            end else if (branch_taken) begin
                rem[k] = 0;
            end else if (halt_req) begin
                mh[k] = 1; rem[k] = 0;
            end else if (rem[k] > 0) begin
                rem[k]--;
            end else if (ref_hazard()) begin
                rem[k] = lb[k] - 1;
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(in_t i);
        id_rs1 = i.rs1; id_rs2 = i.rs2; ex_rd = i.rd;
        id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; ex_is_load = i.ld; ex_writeOrder = i.wr;
        branch_taken = i.br; halt_req = i.hlt;
    endtask

    // One cycle: drive after the falling edge, compare before the next rising edge.
    task automatic drive(in_t i);
        @(negedge clock);
        apply(i);
        #1;
        chk("lb1 ctl", int'(ctl_a), int'(model_ctl(0)));
        chk("lb1 halted", int'(hlt_a), int'(mh[0]));
        chk("lb1 count", int'(cnt_a), mcnt[0]);
        chk("lb3 ctl", int'(ctl_b), int'(model_ctl(1)));
        chk("lb3 halted", int'(hlt_b), int'(mh[1]));
        chk("lb3 count", int'(cnt_b), mcnt[1]);
        model_advance();
    endtask

    // Reset with every input active: outputs must read zero regardless.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        apply(mk(3, 3, 3, 1, 1, 1, 1, 1, 1));
        #1;
        chk("rst ctl lb1", int'({ctl_a, hlt_a}), 0);
        chk("rst ctl lb3", int'({ctl_b, hlt_b}), 0);
        chk("rst count lb1", int'(cnt_a), 0);
        chk("rst count lb3", int'(cnt_b), 0);
        model_reset();
        @(negedge clock);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
    endtask

    in_t  idle;
    in_t  haz3;
    vec_t tab [11];

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        haz3 = mk(3, 0, 3, 1, 0, 1, 1, 0, 0);
        // Expectations for the LOAD_BUBBLES=1 instance.
        tab[0]  = vec(idle, 4'b0000, 0, 0);
        tab[1]  = vec(haz3, 4'b1101, 0, 0);                          // load-use on rs1
        tab[2]  = vec(idle, 4'b0000, 0, 1);                          // single bubble only
        tab[3]  = vec(mk(0, 5, 5, 0, 0, 1, 1, 0, 0), 4'b0000, 0, 1); // rs2 not used
        tab[4]  = vec(mk(0, 5, 5, 0, 1, 1, 0, 0, 0), 4'b0000, 0, 1); // no write
        tab[5]  = vec(mk(0, 5, 5, 0, 1, 0, 1, 0, 0), 4'b0000, 0, 1); // not a load
        tab[6]  = vec(mk(3, 0, 3, 1, 0, 1, 1, 1, 0), 4'b0011, 0, 1); // branch beats hazard
        tab[7]  = vec(idle, 4'b0000, 0, 1);
        tab[8]  = vec(mk(0, 6, 6, 0, 1, 1, 1, 0, 0), 4'b1101, 0, 1); // load-use on rs2
        tab[9]  = vec(mk(0, 0, 0, 1, 0, 1, 1, 0, 0), 4'b1101, 0, 2); // r0 not exempt
        tab[10] = vec(idle, 4'b0000, 0, 3);

        model_reset();
        do_reset();
        for (int n = 0; n < 11; n++) begin
            drive(tab[n].i);
            chk($sformatf("tab%0d ctl", n), int'(ctl_a), int'(tab[n].ctl));
            chk($sformatf("tab%0d halted", n), int'(hlt_a), int'(tab[n].hlt_o));
            chk($sformatf("tab%0d count", n), int'(cnt_a), int'(tab[n].cnt));
        end

        // Three bubbles for one load-use hazard with LOAD_BUBBLES=3.
        begin
            logic [5:0] pat;
            do_reset();
            pat = '0;
            for (int c = 0; c < 6; c++) begin
                drive(c == 0 ? haz3 : idle);
                pat = {pat[4:0], ctl_b[3]};
            end
            chk("lb3 bubble pattern", int'(pat), 6'b111000);
            chk("lb3 bubble count", int'(cnt_b), 3);
            chk("lb1 bubble count", int'(cnt_a), 1);
        end

        // Branch on the second bubble cancels the third.
        do_reset();
        drive(haz3);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("lb3 branch flush", int'(ctl_b), 4'b0011);
        drive(idle);
        chk("lb3 no third bubble", int'(ctl_b), 4'b0000);
        chk("lb3 count after branch", int'(cnt_b), 1);

        // Reset in the middle of a load stall leaves no residue.
        do_reset();
        drive(haz3);
        drive(idle);
        do_reset();
        drive(idle);
        chk("lb3 after mid-stall reset", int'(ctl_b), 4'b0000);

        // Halt: stalls held, counter frozen, only reset exits.
        begin
            int frozen;
            do_reset();
            drive(idle);
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
            chk("halt cycle ctl", int'(ctl_a), 4'b1101);
            chk("halt cycle halted", int'(hlt_a), 0);
            frozen = 1;
            for (int c = 0; c < 100; c++) begin
                drive(mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
            end
            chk("halted held", int'({ctl_a, hlt_a}), 5'b11011);
            chk("halted count frozen", int'(cnt_a), frozen);
            do_reset();
        end

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (mh[0] && $urandom_range(0, 7) == 0) begin
                do_reset();
            end else begin
                drive(mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                         $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                         $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                         $urandom_range(0, 59) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
